// File: rtl/reg_bank_sb.sv
// reg_bank_sb: 3-read/2-write register bank with bypass, PC alias and pending-write scoreboard
module reg_bank_sb #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS),
  localparam int PC_IDX = NREGS - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  input  logic [AW-1:0]    ra3,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic [WIDTH-1:0] rd3,
  input  logic [WIDTH-1:0] r15,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic             we4,
  input  logic [AW-1:0]    wa4,
  input  logic [WIDTH-1:0] wd4,
  input  logic             use1,
  input  logic             use2,
  input  logic             use3,
  input  logic             iss_valid,
  input  logic             iss_dst_en,
  input  logic [AW-1:0]    iss_wa,
  output logic             iss_ready,
  input  logic             flush,
  output logic [AW:0]      pend_cnt,
  output logic [NREGS-1:0] busy
);
  logic [WIDTH-1:0] rf [NREGS-1];
  logic [WIDTH-1:0] rfv [NREGS];
  logic w3, w4, haz;
  logic [NREGS-1:0] clr, set, busy_eff, busy_nxt;
  // PC index writes are dropped entirely: no storage update, no bypass, no scoreboard clear
  assign w3 = we3 && wa3 != AW'(PC_IDX);
  assign w4 = we4 && wa4 != AW'(PC_IDX);
  for (genvar g = 0; g < PC_IDX; g++) begin : g_rfv
    assign rfv[g] = rf[g];
  end
  assign rfv[PC_IDX] = r15;
  assign rd1 = (w4 && wa4 == ra1) ? wd4 : (w3 && wa3 == ra1) ? wd3 : rfv[ra1];
  assign rd2 = (w4 && wa4 == ra2) ? wd4 : (w3 && wa3 == ra2) ? wd3 : rfv[ra2];
  assign rd3 = (w4 && wa4 == ra3) ? wd4 : (w3 && wa3 == ra3) ? wd3 : rfv[ra3];
  always_comb begin
    clr = (NREGS'(w3) << wa3) | (NREGS'(w4) << wa4);
    busy_eff = busy & ~clr;
    haz = (use1 & busy_eff[ra1]) | (use2 & busy_eff[ra2]) | (use3 & busy_eff[ra3]) | (iss_dst_en & busy_eff[iss_wa]);
    set = NREGS'(iss_valid & ~haz & iss_dst_en & (iss_wa != AW'(PC_IDX))) << iss_wa;
    busy_nxt = flush ? '0 : busy_eff | set;
  end
  assign iss_ready = ~haz;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PC_IDX; i++) rf[i] <= '0;
      busy <= '0;
      pend_cnt <= '0;
    end else begin
      if (w3) rf[wa3] <= wd3;
      if (w4) rf[wa4] <= wd4;
      busy <= busy_nxt;
      pend_cnt <= (AW+1)'($countones(busy_nxt));
    end
  end
endmodule
